// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, drives a 1-cycle-latency memory, buffers words toward decode.
// Optional macro FC_PERF_CNT_EN adds fetch and bubble counters (fc_o_fetch_cnt, fc_o_bubble_cnt).
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif
`ifndef IWIDTH
`define IWIDTH 32
`endif

module imem_fetch_ctrl #(
    parameter logic [`PC_WIDTH-1:0] RESET_PC  = '0,
    parameter int unsigned          BUF_DEPTH = 2
) (
    input  logic                 im_clk,
    input  logic                 im_rst,
    input  logic                 fc_i_en,
    input  logic                 fc_i_redirect,
    input  logic [`PC_WIDTH-1:0] fc_i_redirect_pc,
    output logic                 fc_o_mem_ce,
    output logic [`PC_WIDTH-1:0] fc_o_mem_addr,
    input  logic                 fc_i_mem_ce,
    input  logic [`IWIDTH-1:0]   fc_i_mem_instr,
    output logic                 fc_o_valid,
    input  logic                 fc_i_ready,
    output logic [`IWIDTH-1:0]   fc_o_instr,
`ifdef FC_PERF_CNT_EN
    output logic [31:0]          fc_o_fetch_cnt,
    output logic [31:0]          fc_o_bubble_cnt,
`endif
    output logic [`PC_WIDTH-1:0] fc_o_pc
);

    localparam int unsigned PTR_W = (BUF_DEPTH > 2) ? 2 : 1;
    localparam logic [`PC_WIDTH-1:0] ALIGN_MASK = {{(`PC_WIDTH-2){1'b1}}, 2'b00};
    localparam logic [`PC_WIDTH-1:0] RESET_PC_A = RESET_PC & ALIGN_MASK;

    logic [`PC_WIDTH-1:0] fetch_pc;
    logic [`PC_WIDTH-1:0] inflight_pc;
    logic                 inflight;
    logic                 drop;
    logic [`PC_WIDTH-1:0] buf_pc    [BUF_DEPTH];
    logic [`IWIDTH-1:0]   buf_instr [BUF_DEPTH];
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W:0]       count;
    logic [PTR_W+1:0]     occupancy;
    logic                 pop;
    logic                 push;
    logic                 issue;

    // Occupancy counts the in-flight word so a granted request always has a FIFO slot on return.
    always_comb begin
        pop       = (count != '0) & fc_i_ready;
        occupancy = {1'b0, count} + {{(PTR_W+1){1'b0}}, inflight} - {{(PTR_W+1){1'b0}}, pop};
        issue     = im_rst & fc_i_en & ~fc_i_redirect & (occupancy < (PTR_W+2)'(BUF_DEPTH));
        push      = fc_i_mem_ce & inflight & ~drop & ~fc_i_redirect;
    end

    assign fc_o_mem_ce   = issue;
    assign fc_o_mem_addr = fetch_pc;
    assign fc_o_valid    = (count != '0);
    assign fc_o_instr    = buf_instr[rd_ptr];
    assign fc_o_pc       = buf_pc[rd_ptr];

    always_ff @(posedge im_clk or negedge im_rst) begin
        if (!im_rst) begin
            fetch_pc    <= RESET_PC_A;
            inflight_pc <= '0;
            inflight    <= 1'b0;
            drop        <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
                buf_pc[i]    <= '0;
                buf_instr[i] <= '0;
            end
        end else begin
            inflight <= issue;
            drop     <= fc_i_redirect & inflight;
            if (issue)
                inflight_pc <= fetch_pc;
            if (fc_i_redirect) begin
                // Flush wins over any pop or push in the same cycle.
                fetch_pc <= fc_i_redirect_pc & ALIGN_MASK;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
            end else begin
                if (issue)
                    fetch_pc <= fetch_pc + `PC_WIDTH'(4);
                if (push) begin
                    buf_pc[wr_ptr]    <= inflight_pc;
                    buf_instr[wr_ptr] <= fc_i_mem_instr;
                    wr_ptr            <= wr_ptr + PTR_W'(1);
                end
                if (pop)
                    rd_ptr <= rd_ptr + PTR_W'(1);
                if (push && !pop)
                    count <= count + (PTR_W+1)'(1);
                else if (pop && !push)
                    count <= count - (PTR_W+1)'(1);
            end
        end
    end

`ifdef FC_PERF_CNT_EN
    always_ff @(posedge im_clk or negedge im_rst) begin
        if (!im_rst) begin
            fc_o_fetch_cnt  <= '0;
            fc_o_bubble_cnt <= '0;
        end else begin
            if (pop)
                fc_o_fetch_cnt <= fc_o_fetch_cnt + 32'd1;
            if (fc_i_ready && !fc_o_valid)
                fc_o_bubble_cnt <= fc_o_bubble_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl: directed scenarios plus random traffic against a program-order model.
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif
`ifndef IWIDTH
`define IWIDTH 32
`endif

module tb_imem_fetch_ctrl;

    localparam int unsigned PW    = `PC_WIDTH;
    localparam int unsigned IW    = `IWIDTH;
    localparam int          DEPTH = 2;
    localparam logic [PW-1:0] RST_PC = '0;

    logic          im_clk = 1'b0;
    logic          im_rst;
    logic          fc_i_en;
    logic          fc_i_redirect;
    logic [PW-1:0] fc_i_redirect_pc;
    logic          fc_o_mem_ce;
    logic [PW-1:0] fc_o_mem_addr;
    logic          fc_i_mem_ce;
    logic [IW-1:0] fc_i_mem_instr;
    logic          fc_o_valid;
    logic          fc_i_ready;
    logic [IW-1:0] fc_o_instr;
    logic [PW-1:0] fc_o_pc;

    imem_fetch_ctrl #(.RESET_PC(RST_PC), .BUF_DEPTH(DEPTH)) dut (
        .im_clk(im_clk),
        .im_rst(im_rst),
        .fc_i_en(fc_i_en),
        .fc_i_redirect(fc_i_redirect),
        .fc_i_redirect_pc(fc_i_redirect_pc),
        .fc_o_mem_ce(fc_o_mem_ce),
        .fc_o_mem_addr(fc_o_mem_addr),
        .fc_i_mem_ce(fc_i_mem_ce),
        .fc_i_mem_instr(fc_i_mem_instr),
        .fc_o_valid(fc_o_valid),
        .fc_i_ready(fc_i_ready),
        .fc_o_instr(fc_o_instr),
        .fc_o_pc(fc_o_pc)
    );

    always #5 im_clk = ~im_clk;

    int            checks   = 0;
    int            failures = 0;
    // Program-order model: next pc decode must see, next address memory must be asked for.
    logic [PW-1:0] exp_pc;
    logic [PW-1:0] req_pc;
    int            outstanding;
    int            quiet;
    logic          rsp_pend;
    logic [PW-1:0] rsp_addr;
    int            spur_pct;
    logic          s_valid;
    logic          s_ce;

    function automatic logic [IW-1:0] word(input logic [PW-1:0] a);
        return IW'(a >> 2) + IW'(32'h100);
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        exp_pc      = {RST_PC[PW-1:2], 2'b00};
        req_pc      = {RST_PC[PW-1:2], 2'b00};
        outstanding = 0;
        quiet       = 0;
        rsp_pend    = 1'b0;
    endtask

    task automatic reset_checks();
        check("rst_valid", fc_o_valid, 0);
        check("rst_instr", fc_o_instr, 0);
        check("rst_pc", fc_o_pc, 0);
        check("rst_ce", fc_o_mem_ce, 0);
        check("rst_addr", fc_o_mem_addr, {RST_PC[PW-1:2], 2'b00});
    endtask

    // One clock cycle: drive at posedge+1, check at negedge, leave at next posedge+1.
    task automatic cycle(input logic e, input logic r, input logic [PW-1:0] rp, input logic rd);
        logic p;
        logic [PW-1:0] tgt;
        fc_i_en          = e;
        fc_i_redirect    = r;
        fc_i_redirect_pc = rp;
        fc_i_ready       = rd;
        if (rsp_pend) begin
            fc_i_mem_ce    = 1'b1;
            fc_i_mem_instr = word(rsp_addr);
        end else if ($urandom_range(99) < spur_pct) begin
            fc_i_mem_ce    = 1'b1;
            fc_i_mem_instr = $urandom;
        end else begin
            fc_i_mem_ce    = 1'b0;
            fc_i_mem_instr = '0;
        end
        @(negedge im_clk);
        s_valid = fc_o_valid;
        s_ce    = fc_o_mem_ce;
        check("req_addr", fc_o_mem_addr, req_pc);
        if (!e || r)
            check("ce_gate", fc_o_mem_ce, 0);
        if (quiet > 0) begin
            check("stale", fc_o_valid, 0);
            quiet--;
        end
        p = fc_o_valid & rd;
        if (p) begin
            check("head_pc", fc_o_pc, exp_pc);
            check("head_instr", fc_o_instr, word(exp_pc));
            exp_pc = exp_pc + PW'(4);
        end
        if (r) begin
            tgt         = {rp[PW-1:2], 2'b00};
            exp_pc      = tgt;
            req_pc      = tgt;
            outstanding = 0;
            quiet       = 2;
        end else begin
            if (fc_o_mem_ce)
                req_pc = req_pc + PW'(4);
            outstanding = outstanding + int'(fc_o_mem_ce) - int'(p);
            check("occupancy", 64'(outstanding >= 0 && outstanding <= DEPTH), 1);
        end
        rsp_pend = fc_o_mem_ce;
        rsp_addr = fc_o_mem_addr;
        @(posedge im_clk);
        #1;
    endtask

    initial begin
        im_rst = 1'b0;
        fc_i_en = 1'b1;
        fc_i_redirect = 1'b0;
        fc_i_redirect_pc = '0;
        fc_i_ready = 1'b1;
        fc_i_mem_ce = 1'b0;
        fc_i_mem_instr = '0;
        spur_pct = 0;
        model_reset();
        repeat (2) @(posedge im_clk);
        #1;
        reset_checks();

        // Release: request in cycle 0, valid from cycle 2, one per cycle.
        im_rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, 1'b0, '0, 1'b1);
            if (i == 0) check("first_req", s_ce, 1);
            check("stream_valid", s_valid, (i >= 2) ? 1 : 0);
        end

        // Back-pressure: FIFO fills, requests stop, stream resumes contiguous.
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b0, '0, 1'b0);
            check("bp_valid", s_valid, 1);
            if (i >= 1) check("bp_ce", s_ce, 0);
        end
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 1'b0, '0, 1'b1);
            check("bp_resume", s_valid, 1);
        end

        // Redirect to 0x43 with a request in flight: first valid 0x40 three cycles later.
        cycle(1'b1, 1'b1, PW'(32'h43), 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, '0, 1'b1);
            if (i == 0) check("redir_req", s_ce, 1);
            if (i == 2) check("redir_lat", s_valid, 1);
        end
        repeat (3) cycle(1'b1, 1'b0, '0, 1'b1);

        // Redirect together with a pop on a full FIFO.
        repeat (3) cycle(1'b1, 1'b0, '0, 1'b0);
        cycle(1'b1, 1'b1, PW'(32'h200), 1'b1);
        cycle(1'b1, 1'b0, '0, 1'b1);
        check("flush_empty", s_valid, 0);
        repeat (4) cycle(1'b1, 1'b0, '0, 1'b1);

        // Address wrap at the top of the PC space.
        cycle(1'b1, 1'b1, {PW{1'b1}} - PW'(7), 1'b1);
        repeat (8) cycle(1'b1, 1'b0, '0, 1'b1);
        check("wrap_pc", exp_pc >= PW'(4) && exp_pc < PW'(32'h20), 1);

        // Async reset mid-stream with a response due; late responses must be ignored.
        fc_i_en = 1'b1;
        fc_i_ready = 1'b0;
        #2;
        im_rst = 1'b0;
        #1;
        reset_checks();
        repeat (2) @(posedge im_clk);
        #1;
        model_reset();
        im_rst = 1'b1;
        spur_pct = 100;
        for (int i = 0; i < 3; i++) begin
            cycle((i == 2) ? 1'b1 : 1'b0, 1'b0, '0, 1'b1);
            check("post_rst_idle", s_valid, 0);
        end
        spur_pct = 0;
        repeat (6) cycle(1'b1, 1'b0, '0, 1'b1);

        // Random traffic with spurious memory strobes.
        spur_pct = 30;
        for (int i = 0; i < 500; i++) begin
            logic e, r, rd;
            logic [PW-1:0] rp;
            e  = ($urandom_range(99) < 80);
            rd = ($urandom_range(99) < 65);
            r  = ($urandom_range(99) < 6);
            rp = ($urandom_range(3) == 0) ? ({PW{1'b1}} - PW'($urandom_range(15))) : PW'($urandom);
            cycle(e, r, rp, rd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_fetch_ctrl.md
# imem_fetch_ctrl

Instruction-fetch sequencer that sits between the pipeline IF stage and the single-port, 1-cycle-latency instruction memory. Owns the fetch PC, issues word-aligned read requests to the memory's chip-enable/address port, and captures returned words into a small FIFO with valid/ready handshake toward decode. Handles stall (back-pressure), fetch-enable gating and branch/jump redirect, discarding any in-flight response made stale by a redirect.

## Interface
- RESET_PC, 0: fetch address after reset, forced word-aligned.
- BUF_DEPTH, 2: response FIFO entries; legal values 2 or 4.
- im_clk  in  1  clock.
- im_rst  in  1  reset, asynchronous, active-low.
- fc_i_en  in  1  fetch enable; 0 blocks new requests, in-flight read still completes.
- fc_i_redirect  in  1  one-cycle redirect strobe.
- fc_i_redirect_pc  in  `PC_WIDTH  new fetch address, bits [1:0] ignored.
- fc_o_mem_ce  out  1  memory request strobe, drives memory chip enable.
- fc_o_mem_addr  out  `PC_WIDTH  request byte address, bits [1:0] always 0.
- fc_i_mem_ce  in  1  memory response valid, one cycle after request.
- fc_i_mem_instr  in  `IWIDTH  memory response word.
- fc_o_valid  out  1  FIFO head valid.
- fc_i_ready  in  1  decode accepts head.
- fc_o_instr  out  `IWIDTH  head instruction.
- fc_o_pc  out  `PC_WIDTH  head instruction address.

## Operation
- State: fetch_pc, inflight (0/1), inflight_pc, drop flag, FIFO of {pc, instr}, count.
- pop = fc_o_valid & fc_i_ready.
- Issue condition (combinational): fc_i_en & !fc_i_redirect & (count + inflight - pop < BUF_DEPTH). When issuing: fc_o_mem_ce=1, fc_o_mem_addr=fetch_pc; on edge fetch_pc += 4 (wraps mod 2^`PC_WIDTH), inflight<=1, inflight_pc<=fetch_pc. Otherwise fc_o_mem_ce=0, fc_o_mem_addr=fetch_pc.
- Response: when fc_i_mem_ce=1 and inflight=1 and drop=0 → push {inflight_pc, fc_i_mem_instr}. Response with inflight=0 ignored. inflight clears unless re-issued same cycle.
- Redirect: FIFO flushed (count<=0, pop ignored that cycle), fetch_pc<={redirect_pc[W-1:2],2'b00}, drop<=inflight; no issue in redirect cycle. drop clears when the dropped response cycle passes.
- Simultaneous push and pop: both occur, count unchanged. Push never overflows (guaranteed by issue condition).
- fc_o_valid = (count != 0); fc_o_instr/fc_o_pc from head, stable while valid & !ready.

## Timing
- Reset (async assert): fc_o_valid=0, fc_o_instr=0, fc_o_pc=0, fc_o_mem_ce=0, fc_o_mem_addr=RESET_PC, fetch_pc=RESET_PC, inflight=0, drop=0, count=0.
- Reset mid-operation: all state cleared immediately; in-flight response arriving after release ignored (inflight=0).
- First request in cycle 0 after release (if enabled); response in cycle 1; fc_o_valid in cycle 2. Request-to-valid latency 2 cycles.
- With fc_i_ready held 1 and no redirect: one instruction per cycle sustained, BUF_DEPTH=2 sufficient.
- Redirect in cycle R: first request at new PC in R+1, fc_o_valid for it in R+3; no stale instruction ever presented after R.
- fc_i_ready low: FIFO fills to BUF_DEPTH, then fc_o_mem_ce stays 0; no instruction lost or duplicated.

## Configuration
- FC_PERF_CNT_EN: when defined, adds outputs fc_o_fetch_cnt (32 bit, increments on each pop) and fc_o_bubble_cnt (32 bit, increments each cycle fc_i_ready=1 & fc_o_valid=0 while not in reset), both wrap, reset to 0. When undefined, ports and counters absent; no other behaviour change.

## Test plan
- Reset release, RESET_PC=0, ready=1, memory word[i]=i+0x100 -> valid from cycle 2, pcs 0,4,8,... instr 0x100,0x101,... one per cycle.
- ready low for 5 cycles after first valid -> mem_ce drops after FIFO holds 2 entries; on release pcs continue contiguous, no gap/duplicate.
- Redirect to 0x43 while request in flight -> stale response dropped, next valid pc=0x40, latency 3 cycles from redirect.
- Redirect coincident with pop and full FIFO -> FIFO empty next cycle, popped head accepted once only.
- fetch_pc at 2^`PC_WIDTH-4 -> next pc 0 (wrap).
- Async reset asserted mid-stream with response pending -> all outputs to reset values immediately, response after release ignored.
